hilo_div_unit: RTL and testbench

Multi-cycle signed/unsigned divider with the architectural HI/LO register pair, sitting directly downstream of the decode/operand stage. It replaces the combinational divider in the datapath: it accepts a DIV/DIVU request, iterates one quotient bit per cycle, and commits the remainder to HI and the quotient to LO. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. `busy` stalls the pipeline while a division is in flight.

---
 rtl/hilo_pkg.sv | 15 +
 rtl/div_core.sv | 62 ++++++
 rtl/hilo_div_unit.sv | 120 ++++++++++++
 tb/tb_hilo_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide unit: op codes, FSM states, iteration count.
package hilo_pkg;

    localparam int DIV_ITER = 32;

    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step, MSB first.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // The remainder keeps one guard bit so the shifted partial remainder never overflows.
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;

    // Shift in the next dividend bit and trial-subtract; the top bit of diff is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {2'b00, dvs_q};
    end

    // Load operands, then one restoring step per cycle while step is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            if (!diff[WIDTH+1]) begin
                rem_q <= diff[WIDTH:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[WIDTH:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q[WIDTH-1:0];
    assign last = (cnt_q == '0);

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle DIV/DIVU unit owning the architectural HI/LO pair.
//
// state | meaning
// IDLE  | waiting for a DIV/DIVU request; MTHI/MTLO serviced
// RUN   | core iterating one quotient bit per cycle
// FIX   | sign correction and HI/LO commit, pulse done
module hilo_div_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    logic             q_neg;
    logic             r_neg;
    logic             zero_dvs;
    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic             core_last;

    // Request decode and operand magnitudes; a cancel in the same cycle drops the request.
    always_comb begin
        signed_op = (op == OP_DIV);
        accept    = (state == IDLE) && start && !cancel && ((op == OP_DIVU) || (op == OP_DIV));
        a_mag     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag     = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state == RUN),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (core_quo),
        .rem      (core_rem),
        .last     (core_last)
    );

    // Control FSM with registered status and HI/LO; a commit at FIX wins over MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero_dvs    <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (mthi) begin
                hi <= wdata;
            end
            if (mtlo) begin
                lo <= wdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        q_neg    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg    <= signed_op && dividend[WIDTH-1];
                        zero_dvs <= (divisor == '0);
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (core_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        lo          <= q_neg ? -core_quo : core_quo;
                        hi          <= r_neg ? -core_rem : core_rem;
                        done        <= 1'b1;
                        div_by_zero <= zero_dvs;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed cases plus random divisions against an arithmetic model.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; divide by zero gives all-ones magnitude.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        z = (b == 32'd0);
        if (o == 2'b10) begin
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (b == 32'd0) begin
                q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
                r = a;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
        end
    endfunction

    // Issue one division at a negedge; optionally MTLO, cancel or a second start at a given cycle.
    task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int mtlo_at, input int cancel_at, input int restart_at);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          edges;
        int          busy_cyc;
        int          pulses;
        model(o, a, b, eq, er, ez);
        hi0 = hi;
        lo0 = lo;
        start = 1'b1;
        op = o;
        dividend = a;
        divisor = b;
        @(posedge clk);
        edges = 0;
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (edges < 40) begin
            if (busy) busy_cyc++;
            if (done) break;
            mtlo = (edges == mtlo_at);
            wdata = 32'h0000_AAAA;
            cancel = (edges == cancel_at);
            if (edges == restart_at) begin
                start = 1'b1;
                op = 2'b10;
                dividend = 32'd1;
                divisor = 32'd1;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            mtlo = 1'b0;
            cancel = 1'b0;
            start = 1'b0;
            if (mtlo_at >= 0 && edges == mtlo_at + 1) begin
                check({tag, " mtlo_during_run"}, lo, 32'h0000_AAAA);
            end
            if (cancel_at >= 0 && edges == cancel_at + 1) begin
                check({tag, " cancel_busy"}, {31'd0, busy}, 32'd0);
                pulses = 0;
                for (int i = 0; i < 40; i++) begin
                    if (done) pulses++;
                    @(negedge clk);
                end
                check({tag, " cancel_no_done"}, pulses, 32'd0);
                check({tag, " cancel_hi"}, hi, hi0);
                check({tag, " cancel_lo"}, lo, lo0);
                return;
            end
        end
        check({tag, " latency"}, edges, 32'd33);
        check({tag, " busy_cycles"}, busy_cyc, 32'd33);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " lo"}, lo, eq);
        check({tag, " hi"}, hi, er);
        check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI in IDLE
        mthi = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_idle", hi, 32'h0000_1234);

        // Directed divisions
        run_div("divu_34_big", 2'b10, 32'd34, 32'hFFFF_FFFB, -1, -1, -1);
        run_div("div_34_m5", 2'b11, 32'd34, 32'hFFFF_FFFB, -1, -1, -1);
        run_div("div_m34_5", 2'b11, 32'hFFFF_FFDE, 32'd5, -1, -1, -1);
        run_div("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        run_div("divu_7_0", 2'b10, 32'd7, 32'd0, -1, -1, -1);
        run_div("div_m7_0", 2'b11, 32'hFFFF_FFF9, 32'd0, -1, -1, -1);
        run_div("divu_100_7_mtlo", 2'b10, 32'd100, 32'd7, 5, -1, -1);
        run_div("cancel_run10", 2'b10, 32'd1000, 32'd3, -1, 10, -1);
        run_div("restart_busy", 2'b11, 32'hFFFF_FC18, 32'd7, -1, -1, 4);

        // Invalid op and start+cancel in IDLE are both dropped
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        dividend = 32'd5;
        divisor = 32'd1;
        @(posedge clk);
        @(negedge clk);
        check("bad_op_busy", {31'd0, busy}, 32'd0);
        op = 2'b10;
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("start_cancel_busy", {31'd0, busy}, 32'd0);

        // Random back-to-back divisions
        for (int n = 0; n < 24; n++) begin
            ro = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 100));
                2: rb = -32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            run_div($sformatf("rand%0d", n), ro, ra, rb, -1, -1, -1);
        end

        // Asynchronous reset mid-RUN, then a normal division
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        dividend = 32'd1000;
        divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div("divu_9_3", 2'b10, 32'd9, 32'd3, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
